// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: grants one of two cache ports access to a shared memory
// controller, then forwards that port's beat strobes until the transfer ends.
// Optional build macro: CACHE_ARB_FIXED_PRIORITY_EN (port 0 always wins ties);
// when undefined, ties are resolved round-robin.
module cache_mem_arbiter #(
   parameter int unsigned BW_ADDR     = 24,
   parameter int unsigned BLOCK_WORDS = 16
) (
   input  logic               clock_i,
   input  logic               resetn_i,
   input  logic               p0_req_i,
   input  logic               p0_req_block_i,
   input  logic               p0_rw_i,
   input  logic [BW_ADDR-1:0] p0_add_i,
   input  logic               p0_write_i,
   input  logic               p0_read_i,
   input  logic [31:0]        p0_data_i,
   output logic               p0_ready_req_o,
   output logic               p0_ready_write_o,
   output logic               p0_ready_read_o,
   output logic [31:0]        p0_data_o,
   input  logic               p1_req_i,
   input  logic               p1_req_block_i,
   input  logic               p1_rw_i,
   input  logic [BW_ADDR-1:0] p1_add_i,
   input  logic               p1_write_i,
   input  logic               p1_read_i,
   input  logic [31:0]        p1_data_i,
   output logic               p1_ready_req_o,
   output logic               p1_ready_write_o,
   output logic               p1_ready_read_o,
   output logic [31:0]        p1_data_o,
   input  logic               mem_ready_req_i,
   input  logic               mem_ready_write_i,
   input  logic               mem_ready_read_i,
   input  logic [31:0]        mem_data_i,
   output logic               mem_req_o,
   output logic               mem_req_block_o,
   output logic               mem_rw_o,
   output logic [BW_ADDR-1:0] mem_add_o,
   output logic               mem_write_o,
   output logic               mem_read_o,
   output logic [31:0]        mem_data_o,
   output logic               owner_o,
   output logic               busy_o,
   output logic               err_o
);

   localparam int unsigned CW = $clog2(BLOCK_WORDS) + 1;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   state_t        state;
   state_t        state_next;
   logic          owner;
   logic          dir;
   logic [CW-1:0] beats;
   logic [CW-1:0] count;
   logic          err;
   logic          tie_winner;
   logic          winner;
   logic          win_block;
   logic          win_rw;
   logic          accept;
   logic          beat;
   logic          last_beat;
   logic          bad_strobe;
   logic          own_write;
   logic          own_read;
   logic          oth_write;
   logic          oth_read;
   logic [31:0]   own_data;

`ifdef CACHE_ARB_FIXED_PRIORITY_EN
   assign tie_winner = 1'b0;
`else
   logic prio;

   // Round-robin pointer: the port that just finished loses the next tie
   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         prio <= 1'b0;
      end else if (last_beat) begin
         prio <= owner;
      end
   end

   assign tie_winner = ~prio;
`endif

   assign winner    = (p0_req_i & p1_req_i) ? tie_winner : p1_req_i;
   assign win_block = winner ? p1_req_block_i : p0_req_block_i;
   assign win_rw    = winner ? p1_rw_i : p0_rw_i;

   assign own_write = owner ? p1_write_i : p0_write_i;
   assign own_read  = owner ? p1_read_i  : p0_read_i;
   assign oth_write = owner ? p0_write_i : p1_write_i;
   assign oth_read  = owner ? p0_read_i  : p1_read_i;
   assign own_data  = owner ? p1_data_i  : p0_data_i;

   assign p0_data_o = mem_data_i;
   assign p1_data_o = mem_data_i;
   assign owner_o   = owner;
   assign busy_o    = (state == XFER);
   assign err_o     = err;

   // State register
   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state, arbitration and strobe routing; everything forced low in reset
   always_comb begin
      state_next       = state;
      accept           = 1'b0;
      beat             = 1'b0;
      last_beat        = 1'b0;
      bad_strobe       = 1'b0;
      mem_req_o        = 1'b0;
      mem_req_block_o  = 1'b0;
      mem_rw_o         = 1'b0;
      mem_add_o        = '0;
      mem_write_o      = 1'b0;
      mem_read_o       = 1'b0;
      mem_data_o       = '0;
      p0_ready_req_o   = 1'b0;
      p1_ready_req_o   = 1'b0;
      p0_ready_write_o = 1'b0;
      p1_ready_write_o = 1'b0;
      p0_ready_read_o  = 1'b0;
      p1_ready_read_o  = 1'b0;
      if (resetn_i) begin
         case (state)
            IDLE: begin
               if (p0_req_i | p1_req_i) begin
                  mem_req_o       = 1'b1;
                  mem_req_block_o = win_block;
                  mem_rw_o        = win_rw;
                  mem_add_o       = winner ? p1_add_i : p0_add_i;
                  if (winner) begin
                     p1_ready_req_o = mem_ready_req_i;
                  end else begin
                     p0_ready_req_o = mem_ready_req_i;
                  end
                  accept = mem_ready_req_i;
                  if (accept) begin
                     state_next = XFER;
                  end
               end
            end
            XFER: begin
               mem_write_o = own_write & dir;
               mem_read_o  = own_read & ~dir;
               mem_data_o  = own_data;
               if (owner) begin
                  p1_ready_write_o = mem_ready_write_i;
                  p1_ready_read_o  = mem_ready_read_i;
               end else begin
                  p0_ready_write_o = mem_ready_write_i;
                  p0_ready_read_o  = mem_ready_read_i;
               end
               beat       = (dir & own_write & mem_ready_write_i) |
                            (~dir & own_read & mem_ready_read_i);
               bad_strobe = (dir & own_read) | (~dir & own_write) | oth_write | oth_read;
               last_beat  = beat & (count == beats - CW'(1));
               if (last_beat) begin
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Transfer context captured on accept, beat counter, sticky error
   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         owner <= 1'b0;
         dir   <= 1'b0;
         beats <= '0;
         count <= '0;
         err   <= 1'b0;
      end else begin
         if (accept) begin
            owner <= winner;
            dir   <= win_rw;
            beats <= win_block ? CW'(BLOCK_WORDS) : CW'(1);
            count <= '0;
         end else if (beat) begin
            count <= count + CW'(1);
         end
         if (bad_strobe) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level model of the arbiter.
module tb_cache_mem_arbiter;

   localparam int unsigned AW = 24;
   localparam int unsigned BW = 16;
`ifdef CACHE_ARB_FIXED_PRIORITY_EN
   localparam logic FIRST_TIE = 1'b0;
`else
   localparam logic FIRST_TIE = 1'b1;
`endif

   logic          clock_i = 1'b0;
   logic          resetn_i;
   logic          p0_req_i, p0_req_block_i, p0_rw_i, p0_write_i, p0_read_i;
   logic [AW-1:0] p0_add_i;
   logic [31:0]   p0_data_i, p0_data_o;
   logic          p0_ready_req_o, p0_ready_write_o, p0_ready_read_o;
   logic          p1_req_i, p1_req_block_i, p1_rw_i, p1_write_i, p1_read_i;
   logic [AW-1:0] p1_add_i;
   logic [31:0]   p1_data_i, p1_data_o;
   logic          p1_ready_req_o, p1_ready_write_o, p1_ready_read_o;
   logic          mem_ready_req_i, mem_ready_write_i, mem_ready_read_i;
   logic [31:0]   mem_data_i, mem_data_o;
   logic          mem_req_o, mem_req_block_o, mem_rw_o, mem_write_o, mem_read_o;
   logic [AW-1:0] mem_add_o;
   logic          owner_o, busy_o, err_o;

   int total = 0;
   int bad   = 0;

   // Model: an open transfer is (owner, direction, beats remaining)
   logic m_busy, m_owner, m_dir, m_prio, m_err;
   int   m_left;

   cache_mem_arbiter #(.BW_ADDR(AW), .BLOCK_WORDS(BW)) dut (
      .clock_i(clock_i), .resetn_i(resetn_i),
      .p0_req_i(p0_req_i), .p0_req_block_i(p0_req_block_i), .p0_rw_i(p0_rw_i),
      .p0_add_i(p0_add_i), .p0_write_i(p0_write_i), .p0_read_i(p0_read_i),
      .p0_data_i(p0_data_i), .p0_ready_req_o(p0_ready_req_o),
      .p0_ready_write_o(p0_ready_write_o), .p0_ready_read_o(p0_ready_read_o),
      .p0_data_o(p0_data_o),
      .p1_req_i(p1_req_i), .p1_req_block_i(p1_req_block_i), .p1_rw_i(p1_rw_i),
      .p1_add_i(p1_add_i), .p1_write_i(p1_write_i), .p1_read_i(p1_read_i),
      .p1_data_i(p1_data_i), .p1_ready_req_o(p1_ready_req_o),
      .p1_ready_write_o(p1_ready_write_o), .p1_ready_read_o(p1_ready_read_o),
      .p1_data_o(p1_data_o),
      .mem_ready_req_i(mem_ready_req_i), .mem_ready_write_i(mem_ready_write_i),
      .mem_ready_read_i(mem_ready_read_i), .mem_data_i(mem_data_i),
      .mem_req_o(mem_req_o), .mem_req_block_o(mem_req_block_o), .mem_rw_o(mem_rw_o),
      .mem_add_o(mem_add_o), .mem_write_o(mem_write_o), .mem_read_o(mem_read_o),
      .mem_data_o(mem_data_o), .owner_o(owner_o), .busy_o(busy_o), .err_o(err_o)
   );

   always #5 clock_i = ~clock_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic reset_model();
      m_busy  = 1'b0;
      m_owner = 1'b0;
      m_dir   = 1'b0;
      m_prio  = 1'b0;
      m_err   = 1'b0;
      m_left  = 0;
   endtask

   function automatic logic model_winner();
      if (p0_req_i && p1_req_i) begin
`ifdef CACHE_ARB_FIXED_PRIORITY_EN
         return 1'b0;
`else
         return ~m_prio;
`endif
      end
      return p1_req_i;
   endfunction

   // Compare every output with what the model says this cycle
   task automatic check_outputs();
      logic          w;
      logic          e_req, e_blk, e_rw, e_wr, e_rd;
      logic          e_rr0, e_rr1, e_rw0, e_rw1, e_rd0, e_rd1;
      logic [AW-1:0] e_add;
      logic [31:0]   e_dat;
      {e_req, e_blk, e_rw, e_wr, e_rd} = '0;
      {e_rr0, e_rr1, e_rw0, e_rw1, e_rd0, e_rd1} = '0;
      e_add = '0;
      e_dat = '0;
      if (resetn_i) begin
         if (!m_busy) begin
            if (p0_req_i || p1_req_i) begin
               w     = model_winner();
               e_req = 1'b1;
               e_blk = w ? p1_req_block_i : p0_req_block_i;
               e_rw  = w ? p1_rw_i : p0_rw_i;
               e_add = w ? p1_add_i : p0_add_i;
               e_rr1 = w & mem_ready_req_i;
               e_rr0 = !w & mem_ready_req_i;
            end
         end else begin
            e_wr  = (m_owner ? p1_write_i : p0_write_i) & m_dir;
            e_rd  = (m_owner ? p1_read_i : p0_read_i) & !m_dir;
            e_dat = m_owner ? p1_data_i : p0_data_i;
            e_rw1 = m_owner & mem_ready_write_i;
            e_rd1 = m_owner & mem_ready_read_i;
            e_rw0 = !m_owner & mem_ready_write_i;
            e_rd0 = !m_owner & mem_ready_read_i;
         end
      end
      chk("mem_req", 32'(mem_req_o), 32'(e_req));
      chk("mem_req_block", 32'(mem_req_block_o), 32'(e_blk));
      chk("mem_rw", 32'(mem_rw_o), 32'(e_rw));
      chk("mem_add", 32'(mem_add_o), 32'(e_add));
      chk("mem_write", 32'(mem_write_o), 32'(e_wr));
      chk("mem_read", 32'(mem_read_o), 32'(e_rd));
      chk("mem_data", mem_data_o, e_dat);
      chk("p0_ready_req", 32'(p0_ready_req_o), 32'(e_rr0));
      chk("p1_ready_req", 32'(p1_ready_req_o), 32'(e_rr1));
      chk("p0_ready_write", 32'(p0_ready_write_o), 32'(e_rw0));
      chk("p1_ready_write", 32'(p1_ready_write_o), 32'(e_rw1));
      chk("p0_ready_read", 32'(p0_ready_read_o), 32'(e_rd0));
      chk("p1_ready_read", 32'(p1_ready_read_o), 32'(e_rd1));
      chk("p0_data", p0_data_o, mem_data_i);
      chk("p1_data", p1_data_o, mem_data_i);
      chk("busy", 32'(busy_o), 32'(m_busy));
      chk("owner", 32'(owner_o), 32'(m_owner));
      chk("err", 32'(err_o), 32'(m_err));
   endtask

   // Advance the model by one clock using the inputs present at the edge
   task automatic model_clock();
      logic ow, orr, xw, xr;
      if (!resetn_i) return;
      if (!m_busy) begin
         if ((p0_req_i || p1_req_i) && mem_ready_req_i) begin
            m_owner = model_winner();
            m_dir   = m_owner ? p1_rw_i : p0_rw_i;
            m_left  = (m_owner ? p1_req_block_i : p0_req_block_i) ? BW : 1;
            m_busy  = 1'b1;
         end
      end else begin
         ow  = m_owner ? p1_write_i : p0_write_i;
         orr = m_owner ? p1_read_i : p0_read_i;
         xw  = m_owner ? p0_write_i : p1_write_i;
         xr  = m_owner ? p0_read_i : p1_read_i;
         if ((m_dir && orr) || (!m_dir && ow) || xw || xr) m_err = 1'b1;
         if ((m_dir && ow && mem_ready_write_i) || (!m_dir && orr && mem_ready_read_i)) begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 1'b0;
               m_prio = m_owner;
            end
         end
      end
   endtask

   // Inputs are set at the falling edge; check, clock, return to falling edge
   task automatic step();
      #1 check_outputs();
      @(posedge clock_i);
      model_clock();
      @(negedge clock_i);
   endtask

   task automatic clear_inputs();
      {p0_req_i, p0_req_block_i, p0_rw_i, p0_write_i, p0_read_i} = '0;
      {p1_req_i, p1_req_block_i, p1_rw_i, p1_write_i, p1_read_i} = '0;
      p0_add_i = '0;
      p1_add_i = '0;
      p0_data_i = '0;
      p1_data_i = '0;
      {mem_ready_req_i, mem_ready_write_i, mem_ready_read_i} = '0;
      mem_data_i = '0;
   endtask

   task automatic drive_owner_read();
      p0_read_i = m_busy & !m_owner;
      p1_read_i = m_busy & m_owner;
   endtask

   initial begin
      clear_inputs();
      resetn_i = 1'b0;
      reset_model();
      @(negedge clock_i);
      // Outputs stay quiet while reset is held even with live requests
      p0_req_i = 1'b1; p1_req_i = 1'b1; mem_ready_req_i = 1'b1;
      step();
      chk("reset_busy", 32'(busy_o), 32'd0);
      resetn_i = 1'b1;

      // Tie after reset, two back-to-back block reads
      p0_req_block_i = 1'b1; p1_req_block_i = 1'b1; mem_ready_read_i = 1'b1;
      step();
      chk("tie1_owner", 32'(owner_o), 32'(FIRST_TIE));
      for (int i = 0; i < 15; i++) begin drive_owner_read(); step(); end
      chk("tie1_before_last", 32'(busy_o), 32'd1);
      drive_owner_read(); step();
      chk("tie1_done", 32'(busy_o), 32'd0);
      drive_owner_read(); step();
      chk("tie2_owner", 32'(owner_o), 32'd0);
      chk("tie2_busy", 32'(busy_o), 32'd1);
      for (int i = 0; i < 16; i++) begin drive_owner_read(); step(); end
      clear_inputs();
      step();
      chk("tie_no_err", 32'(err_o), 32'd0);

      // Single-word write from port 0
      p0_req_i = 1'b1; p0_rw_i = 1'b1; p0_add_i = 24'h000123; mem_ready_req_i = 1'b1;
      #1 chk("sw_addr", 32'(mem_add_o), 32'h000123);
      chk("sw_busy_before", 32'(busy_o), 32'd0);
      step();
      chk("sw_busy_during", 32'(busy_o), 32'd1);
      p0_req_i = 1'b0; p0_write_i = 1'b1; p0_data_i = 32'hCAFE_0001; mem_ready_write_i = 1'b1;
      step();
      chk("sw_busy_after", 32'(busy_o), 32'd0);
      clear_inputs();

      // Block read with the memory read-ready toggling
      p0_req_i = 1'b1; p0_req_block_i = 1'b1; mem_ready_req_i = 1'b1;
      step();
      p0_req_i = 1'b0;
      for (int i = 0; i < 30; i++) begin
         p0_read_i = 1'b1; mem_ready_read_i = (i % 2 == 0); mem_data_i = $urandom; step();
      end
      chk("stall_busy_15", 32'(busy_o), 32'd1);
      mem_ready_read_i = 1'b1; step();
      chk("stall_done", 32'(busy_o), 32'd0);
      clear_inputs();

      // Non-owner write during a port 0 read
      p0_req_i = 1'b1; p0_req_block_i = 1'b1; mem_ready_req_i = 1'b1;
      step();
      clear_inputs();
      p0_read_i = 1'b1; p1_write_i = 1'b1;
      #1 chk("nonowner_write_blocked", 32'(mem_write_o), 32'd0);
      step();
      chk("nonowner_err", 32'(err_o), 32'd1);
      p1_write_i = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk("err_sticky", 32'(err_o), 32'd1);

      // Reset at beat 7 of a block read, then a fresh request
      resetn_i = 1'b0; reset_model(); step();
      resetn_i = 1'b1; clear_inputs();
      p0_req_i = 1'b1; p0_req_block_i = 1'b1; mem_ready_req_i = 1'b1; mem_ready_read_i = 1'b1;
      step();
      p0_req_i = 1'b0;
      for (int i = 0; i < 7; i++) begin p0_read_i = 1'b1; step(); end
      resetn_i = 1'b0; reset_model();
      #1 chk("midreset_busy", 32'(busy_o), 32'd0);
      chk("midreset_err", 32'(err_o), 32'd0);
      step();
      resetn_i = 1'b1; clear_inputs();
      p1_req_i = 1'b1; mem_ready_req_i = 1'b1;
      step();
      chk("fresh_owner", 32'(owner_o), 32'd1);
      chk("fresh_busy", 32'(busy_o), 32'd1);
      p1_req_i = 1'b0; p1_read_i = 1'b1; mem_ready_read_i = 1'b1;
      step();
      chk("fresh_done", 32'(busy_o), 32'd0);
      clear_inputs();

      // Randomized traffic with occasional protocol errors and resets
      for (int c = 0; c < 3000; c++) begin
         resetn_i = ($urandom_range(0, 399) != 0);
         if (!resetn_i) reset_model();
         p0_req_i = ($urandom_range(0, 2) == 0);
         p1_req_i = ($urandom_range(0, 2) == 0);
         p0_req_block_i = 1'($urandom); p1_req_block_i = 1'($urandom);
         p0_rw_i = 1'($urandom); p1_rw_i = 1'($urandom);
         p0_add_i = AW'($urandom); p1_add_i = AW'($urandom);
         p0_data_i = $urandom; p1_data_i = $urandom; mem_data_i = $urandom;
         mem_ready_req_i = 1'($urandom);
         mem_ready_write_i = 1'($urandom);
         mem_ready_read_i = 1'($urandom);
         {p0_write_i, p0_read_i, p1_write_i, p1_read_i} = '0;
         if (m_busy && $urandom_range(0, 3) != 0) begin
            if (m_owner) begin p1_write_i = m_dir; p1_read_i = !m_dir; end
            else begin p0_write_i = m_dir; p0_read_i = !m_dir; end
         end
         if ($urandom_range(0, 99) == 0) begin
            if ($urandom_range(0, 1) == 0) p0_write_i = 1'b1; else p1_read_i = 1'b1;
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
